// File: rtl/beu_clmul_seq.sv
// Iterative carry-less multiplier for clmul/clmulh/clmulr.
// Retires BITS_PER_CYCLE multiplier bits per cycle and exits early once the remaining multiplier is zero.
module beu_clmul_seq #(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        s_flush_i,
  input  logic        s_start_i,
  input  logic [1:0]  s_fun_i,
  input  logic [31:0] s_op1_i,
  input  logic [31:0] s_op2_i,
  output logic        s_busy_o,
  output logic        s_valid_o,
  output logic [31:0] s_result_o
);

  if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 &&
      BITS_PER_CYCLE != 4 && BITS_PER_CYCLE != 8) begin : g_bad_bpc
    $error("beu_clmul_seq: BITS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [63:0] r_acc;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [1:0]  r_fun;
  logic [31:0] r_result;

  logic        w_accept;
  logic [63:0] w_acc_next;
  logic [63:0] w_mcand_next;
  logic [31:0] w_mplier_next;
  logic [31:0] w_sel;

  assign w_accept = (r_state == ST_IDLE || r_state == ST_DONE) && s_start_i && !s_flush_i;

  // One RUN step: fold the low multiplier bits into the accumulator with XOR (GF(2) product)
  always_comb begin
    w_acc_next = r_acc;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (r_mplier[k]) begin
        w_acc_next = w_acc_next ^ (r_mcand << k);
      end
    end
    w_mcand_next  = r_mcand << BITS_PER_CYCLE;
    w_mplier_next = r_mplier >> BITS_PER_CYCLE;
  end

  always_comb begin
    w_sel = 32'd0;
    case (r_fun)
      2'b00:   w_sel = w_acc_next[31:0];
      2'b01:   w_sel = w_acc_next[63:32];
      2'b10:   w_sel = w_acc_next[62:31];
      default: w_sel = 32'd0;
    endcase
  end

  always_ff @(posedge s_clk_i) begin
    if (!s_resetn_i) begin
      r_state  <= ST_IDLE;
      r_acc    <= 64'd0;
      r_mcand  <= 64'd0;
      r_mplier <= 32'd0;
      r_fun    <= 2'd0;
      r_result <= 32'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (s_flush_i) begin
            r_state <= ST_IDLE;
          end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= w_mcand_next;
            r_mplier <= w_mplier_next;
            if (w_mplier_next == 32'd0) begin
              r_state  <= ST_DONE;
              r_result <= w_sel;
            end
          end
        end
        default: begin
          // IDLE and DONE both accept; DONE falls back to IDLE otherwise
          if (w_accept) begin
            r_state  <= ST_RUN;
            r_acc    <= 64'd0;
            r_mcand  <= {32'd0, s_op1_i};
            r_mplier <= s_op2_i;
            r_fun    <= s_fun_i;
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign s_busy_o   = (r_state == ST_RUN);
  assign s_valid_o  = (r_state == ST_DONE);
  assign s_result_o = r_result;

endmodule

// File: tb/tb_beu_clmul_seq.sv
// Self-checking bench for beu_clmul_seq: directed operations plus a cycle-level reference model
// built from the product definition and an operation-latency countdown.
module tb_beu_clmul_seq;

  localparam int BPC = 4;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        start;
  logic [1:0]  fun;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  int nChecks = 0;
  int nFails  = 0;
  bit checkEn = 0;

  beu_clmul_seq #(.BITS_PER_CYCLE(BPC)) dut (
    .s_clk_i   (clk),
    .s_resetn_i(resetn),
    .s_flush_i (flush),
    .s_start_i (start),
    .s_fun_i   (fun),
    .s_op1_i   (op1),
    .s_op2_i   (op2),
    .s_busy_o  (busy),
    .s_valid_o (valid),
    .s_result_o(result)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference: full 63-bit carry-less product, then pick the requested window
  function automatic logic [31:0] modelResult(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'd0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) p = p ^ ({32'd0, a} << i);
    end
    case (f)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return p[62:31];
      default: return 32'd0;
    endcase
  endfunction

  function automatic int runCycles(input logic [31:0] b);
    int msb;
    msb = -1;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) msb = i;
    end
    if (msb < 0) return 1;
    return (msb + BPC) / BPC;
  endfunction

  int          mLeft = 0;
  logic        mValid = 0;
  logic [31:0] mResult = 0;
  logic [31:0] mPending = 0;

  always @(posedge clk) begin
    if (!resetn) begin
      mLeft = 0; mValid = 0; mResult = 0;
    end else if (flush) begin
      mLeft = 0; mValid = 0;
    end else if (mLeft > 0) begin
      mLeft = mLeft - 1;
      if (mLeft == 0) begin
        mValid  = 1;
        mResult = mPending;
      end else begin
        mValid = 0;
      end
    end else if (start) begin
      mLeft    = runCycles(op2);
      mPending = modelResult(fun, op1, op2);
      mValid   = 0;
    end else begin
      mValid = 0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model busy", {31'd0, busy}, {31'd0, (mLeft > 0)});
      checkOutput("model valid", {31'd0, valid}, {31'd0, mValid});
      checkOutput("model result", result, mResult);
      checkOutput("busy/valid exclusive", {31'd0, busy & valid}, 32'd0);
    end
  end

  // Issue one request, then watch for its pulse; returns at the negedge of the DONE cycle
  task automatic applyStimulus(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expRes, input int expR);
    int n;
    int busyCnt;
    bit seen;
    @(negedge clk);
    start = 1; fun = f; op1 = a; op2 = b;
    @(negedge clk);
    start = 0;
    n = 1; busyCnt = 0; seen = 0;
    while (!seen && n <= 20) begin
      if (valid) seen = 1;
      else begin
        if (busy) busyCnt++;
        @(negedge clk);
        n++;
      end
    end
    checkOutput("valid latency", n, expR + 1);
    checkOutput("busy cycles", busyCnt, expR);
    checkOutput("op result", result, expRes);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;
    resetn = 0; flush = 0; start = 0; fun = 0; op1 = 0; op2 = 0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset valid", {31'd0, valid}, 32'd0);
    checkOutput("reset result", result, 32'd0);
    checkEn = 1;
    resetn = 1;

    applyStimulus(2'b00, 32'h3, 32'h3, 32'h0000_0005, 1);
    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 8);
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 8);
    applyStimulus(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 8);
    applyStimulus(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 8);
    applyStimulus(2'b10, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 8);
    applyStimulus(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 8);
    applyStimulus(2'b01, 32'h0000_1234, 32'h0000_0100, 32'h0000_0000, 3);
    applyStimulus(2'b00, 32'h0000_1234, 32'h0000_0100, 32'h0012_3400, 3);
    applyStimulus(2'b11, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 8);
    applyStimulus(2'b00, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000, 1);
    applyStimulus(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 8);

    // Flush in the third RUN cycle of a full-width op
    @(negedge clk);
    start = 1; fun = 2'b00; op1 = 32'hFFFF_FFFF; op2 = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    checkOutput("flush busy", {31'd0, busy}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (valid) pulses++;
      @(negedge clk);
    end
    checkOutput("flush pulses", pulses, 0);
    checkOutput("flush result kept", result, 32'hAAAA_AAAA);
    applyStimulus(2'b00, 32'h3, 32'h3, 32'h0000_0005, 1);

    // Back-to-back: new request during the DONE cycle
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 8);
    start = 1; fun = 2'b00; op1 = 32'h3; op2 = 32'h3;
    @(negedge clk);
    start = 0;
    checkOutput("b2b busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    checkOutput("b2b valid", {31'd0, valid}, 32'd1);
    checkOutput("b2b result", result, 32'h0000_0005);

    // Start during RUN is ignored
    @(negedge clk);
    start = 1; fun = 2'b00; op1 = 32'hFFFF_FFFF; op2 = 32'hFFFF_FFFF;
    @(negedge clk);
    fun = 2'b01; op1 = 32'h3; op2 = 32'h3;
    @(negedge clk);
    start = 0;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      if (valid) pulses++;
      @(negedge clk);
    end
    checkOutput("run start ignored pulses", pulses, 1);
    checkOutput("run start ignored result", result, 32'h5555_5555);

    // Reset mid-operation clears the result and kills the pulse
    @(negedge clk);
    start = 1; fun = 2'b10; op1 = 32'hFFFF_FFFF; op2 = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    resetn = 0;
    @(negedge clk);
    resetn = 1;
    checkOutput("midreset result", result, 32'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (valid) pulses++;
      @(negedge clk);
    end
    checkOutput("midreset pulses", pulses, 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
